// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment codes, anode codes and scan FSM state
// Contents:
//   SEG_0..SEG_9  active-low g..a patterns for BCD 0..9
//   SEG_BLANK     all segments off
//   AN_D0..AN_D3  active-low anode codes selecting exactly one digit
//   scan_state_t  dwell qualification FSM states
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_D3 = 4'b0111;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D0 = 4'b1110;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low seven-segment to BCD decoder
// Ports:
//   seg   in  7  active-low segment lines g..a
//   bcd   out 4  decoded digit (0 when illegal)
//   legal out 1  high when seg is one of the ten digit patterns
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd   = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers BCD digits from a multiplexed seven-segment scan
// Ports:
//   clk          in  1   system clock
//   rst          in  1   synchronous active-high reset
//   wei          in  4   active-low anode selects, wei[i]=0 selects digit i
//   qc           in  8   active-low segment lines, qc[7]=dp, qc[6:0]=g..a
//   digits       out 16  recovered BCD, digit i at digits[4i+3:4i]
//   digit_valid  out 4   digit i last decoded legally
//   dp_on        out 4   dp state of the last capture of digit i
//   frame_done   out 1   pulse: all FRAME_MASK digits captured since last pulse
//   seg_err      out 1   pulse: captured dwell had an undefined segment pattern
//   anode_err    out 1   pulse: captured dwell had more than one anode low
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic [3:0]  FRAME_MASK    = 4'b1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wei,
  input  logic [7:0]  qc,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp_on,
  output logic        frame_done,
  output logic        seg_err,
  output logic        anode_err
);

  localparam logic [15:0] STABLE_MAX  = 16'(STABLE_CYCLES);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  logic [11:0]  sync1, sync2;
  logic [3:0]   s_wei;
  logic [7:0]   s_qc;
  logic         sample_changed;
  logic [15:0]  cnt;
  scan_state_t  state, state_next;
  logic [3:0]   seen;

  logic [3:0]   bcd;
  logic         legal;
  logic [3:0]   new_bit;
  logic         an_single, an_blank, an_multi;
  logic         cap_legal, cap_illegal, cap_multi;
  logic [3:0]   seen_or;
  logic         frame_hit;

  // Sync flops reset to the idle pattern so a dwell already on the bus
  // when reset drops is seen as a change and re-qualified from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {wei, qc};
      sync2 <= sync1;
    end
  end

  assign s_wei = sync2[11:8];
  assign s_qc  = sync2[7:0];
  // Compares the sample about to be taken against the current one, so the
  // count restarts on the same edge the new value lands in s_wei/s_qc.
  assign sample_changed = (sync1 != sync2);

  always_ff @(posedge clk) begin
    if (rst || sample_changed) begin
      cnt <= 16'd0;
    end else if (cnt != STABLE_MAX) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SETTLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_SETTLE:  if (!sample_changed && cnt == STABLE_LAST) state_next = ST_CAPTURE;
      // A change arriving during the capture cycle must not be lost in HOLD.
      ST_CAPTURE: state_next = sample_changed ? ST_SETTLE : ST_HOLD;
      ST_HOLD:    if (sample_changed) state_next = ST_SETTLE;
      default:    state_next = ST_SETTLE;
    endcase
  end

  seg7_to_bcd u_dec (
    .seg   (s_qc[6:0]),
    .bcd   (bcd),
    .legal (legal)
  );

  always_comb begin
    new_bit   = 4'b0000;
    an_single = 1'b0;
    an_blank  = 1'b0;
    case (s_wei)
      AN_D0:   begin new_bit = 4'b0001; an_single = 1'b1; end
      AN_D1:   begin new_bit = 4'b0010; an_single = 1'b1; end
      AN_D2:   begin new_bit = 4'b0100; an_single = 1'b1; end
      AN_D3:   begin new_bit = 4'b1000; an_single = 1'b1; end
      4'b1111: an_blank = 1'b1;
      default: ;
    endcase
    an_multi    = !an_single && !an_blank;
    cap_legal   = (state == ST_CAPTURE) && an_single && legal;
    cap_illegal = (state == ST_CAPTURE) && an_single && !legal;
    cap_multi   = (state == ST_CAPTURE) && an_multi;
    seen_or     = seen | new_bit;
    frame_hit   = cap_legal && ((seen_or & FRAME_MASK) == FRAME_MASK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= 16'd0;
      digit_valid <= 4'd0;
      dp_on       <= 4'd0;
      seen        <= 4'd0;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      frame_done <= frame_hit;
      seg_err    <= cap_illegal;
      anode_err  <= cap_multi;
      for (int i = 0; i < 4; i++) begin
        if (cap_legal && new_bit[i]) begin
          digits[4*i +: 4] <= bcd;
          digit_valid[i]   <= 1'b1;
          dp_on[i]         <= ~s_qc[7];
        end else if (cap_illegal && new_bit[i]) begin
          digit_valid[i] <= 1'b0;
        end
      end
      if (cap_legal) begin
        seen <= frame_hit ? 4'd0 : seen_or;
      end else if (cap_illegal || cap_multi) begin
        seen <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int         S    = 4;
  localparam logic [3:0] MASK = 4'b1100;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wei;
  logic [7:0]  qc;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  dp_on;
  logic        frame_done;
  logic        seg_err;
  logic        anode_err;

  seg_scan_decoder #(
    .STABLE_CYCLES (S),
    .FRAME_MASK    (MASK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wei         (wei),
    .qc          (qc),
    .digits      (digits),
    .digit_valid (digit_valid),
    .dp_on       (dp_on),
    .frame_done  (frame_done),
    .seg_err     (seg_err),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  dp;
    bit          fd;
    bit          se;
    bit          ae;
  } ev_t;

  typedef struct {
    logic [3:0] wei;
    logic [7:0] qc;
    bit         legal;
    logic [3:0] bcd;
  } vec_t;

  ev_t  sb[$];
  ev_t  ev;
  vec_t tbl[40];
  logic [6:0] pats[10];

  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_dp, m_seen;
  logic [15:0] cur_digits;
  logic [3:0]  cur_valid, cur_dp;
  logic [2:0]  exp_p;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour of one qualified dwell; result queued for its due cycle.
  task automatic model_capture(input logic [3:0] w, input logic [7:0] q, input bit legal,
                               input logic [3:0] bcd, input int due);
    int nz = 0;
    int idx = 0;
    ev_t e;
    logic [3:0] so;
    for (int i = 0; i < 4; i++) begin
      if (!w[i]) begin
        nz++;
        idx = i;
      end
    end
    if (nz == 0) return;
    e.due = due; e.fd = 0; e.se = 0; e.ae = 0;
    if (nz > 1) begin
      m_seen = 4'd0;
      e.ae = 1;
    end else if (!legal) begin
      m_valid[idx] = 1'b0;
      m_seen = 4'd0;
      e.se = 1;
    end else begin
      m_digits[4*idx +: 4] = bcd;
      m_valid[idx] = 1'b1;
      m_dp[idx] = ~q[7];
      so = m_seen | (4'b0001 << idx);
      e.fd = ((so & MASK) == MASK);
      m_seen = e.fd ? 4'd0 : so;
    end
    e.digits = m_digits; e.valid = m_valid; e.dp = m_dp;
    sb.push_back(e);
  endtask

  // Called #1 after a posedge; holds the pattern for n cycles.
  task automatic dwell(input logic [3:0] w, input logic [7:0] q, input int n,
                       input bit legal, input logic [3:0] bcd);
    wei = w;
    qc  = q;
    if (n >= S + 1) model_capture(w, q, legal, bcd, cyc + 3 + S);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_p = 3'b000;
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("sb_overdue", 32'(sb[0].due), 32'(cyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ev = sb.pop_front();
        cur_digits = ev.digits;
        cur_valid  = ev.valid;
        cur_dp     = ev.dp;
        exp_p      = {ev.fd, ev.se, ev.ae};
      end
      check("out_state", {8'd0, digits, digit_valid, dp_on}, {8'd0, cur_digits, cur_valid, cur_dp});
      check("pulses", {29'd0, frame_done, seg_err, anode_err}, {29'd0, exp_p});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    for (int a = 0; a < 4; a++) begin
      for (int v = 0; v < 10; v++) begin
        logic [3:0] w;
        w = 4'b0001 << a;
        tbl[a*10+v].wei   = ~w;
        tbl[a*10+v].qc    = {((v % 2) == 0) ? 1'b1 : 1'b0, pats[v]};
        tbl[a*10+v].legal = 1'b1;
        tbl[a*10+v].bcd   = 4'(v);
      end
    end

    m_digits = 0; m_valid = 0; m_dp = 0; m_seen = 0;
    cur_digits = 0; cur_valid = 0; cur_dp = 0;
    rst = 1'b1; wei = 4'hF; qc = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_dp", 32'(dp_on), 32'h0);
    check("rst_pulses", {29'd0, frame_done, seg_err, anode_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Normal capture: digit 3 = 2, digit 2 = 4, frame on each pair
    for (int p = 0; p < 4; p++) begin
      dwell(4'b0111, 8'hA4, 20, 1, 4'd2);
      dwell(4'b1011, 8'h99, 20, 1, 4'd4);
    end
    check("normal_digits_hi", 32'(digits[15:8]), 32'h24);
    check("normal_valid", 32'(digit_valid), 32'hC);

    // Glitch rejection
    dwell(4'b0111, 8'hC0, 20, 1, 4'd0);
    dwell(4'b0111, 8'hF9, 3, 1, 4'd1);
    dwell(4'b0111, 8'hC0, 20, 1, 4'd0);
    check("glitch_digit3", 32'(digits[15:12]), 32'h0);

    // Illegal pattern clears seen and digit_valid[2]
    dwell(4'b0111, 8'hA4, 20, 1, 4'd2);
    dwell(4'b1011, 8'hFF, 20, 0, 4'd0);
    check("illegal_valid2", 32'(digit_valid[2]), 32'h0);
    dwell(4'b1011, 8'h99, 20, 1, 4'd4);
    dwell(4'b0111, 8'hA4, 20, 1, 4'd2);

    // Anode fault
    dwell(4'b0111, 8'hA4, 20, 1, 4'd2);
    dwell(4'b0011, 8'hC0, 20, 1, 4'd0);
    dwell(4'b1011, 8'h99, 20, 1, 4'd4);
    dwell(4'b0111, 8'hA4, 20, 1, 4'd2);

    // Identical dwells separated by blank
    dwell(4'b0111, 8'hA4, 20, 1, 4'd2);
    dwell(4'b1111, 8'hFF, 20, 1, 4'd0);
    dwell(4'b0111, 8'hA4, 20, 1, 4'd2);

    // Full-range sweep from the table
    for (int i = 0; i < 40; i++) begin
      dwell(tbl[i].wei, tbl[i].qc, 20, tbl[i].legal, tbl[i].bcd);
      check("sweep_bcd", 32'(digits[4*(i/10) +: 4]), 32'(tbl[i].bcd));
    end

    // Latency and reset mid-dwell
    wei = 4'b1110; qc = 8'h90;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outputs", {8'd0, digits, digit_valid, dp_on}, 32'h0);
    check("midrst_pulses", {29'd0, frame_done, seg_err, anode_err}, 32'h0);
    m_digits = 0; m_valid = 0; m_dp = 0; m_seen = 0;
    cur_digits = 0; cur_valid = 0; cur_dp = 0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    model_capture(4'b1110, 8'h90, 1, 4'd9, cyc + 3 + S);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("no_cap_k6_outputs", {8'd0, digits, digit_valid, dp_on}, 32'h0);
    check("no_cap_k6_pulses", {29'd0, frame_done, seg_err, anode_err}, 32'h0);
    mon_en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("relat_digit0", 32'(digits[3:0]), 32'h9);
    check("relat_valid", 32'(digit_valid), 32'h1);
    check("relat_dp0", 32'(dp_on[0]), 32'h0);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
